pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: prioritised per-stage stop bus, multi-cycle MDU
// EX-stall sequencer and a saturating stall-cycle performance counter.
module pipe_ctrl #(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               mdu_start,
    input  logic [5:0]         mdu_cycles,
    input  logic               except_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               mdu_busy,
    output logic               mdu_done,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // Bit 0 is PC; a stage stall also stops every stage upstream of it.
    localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);

    state_t           state_q, state_d;
    logic [5:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [5:0]       n_eff;
    logic             start_ok;

    assign n_eff    = (mdu_cycles == 6'd0) ? 6'd1 : mdu_cycles;
    assign start_ok = (state_q == RUN) && mdu_start;

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path through the block can infer a latch.
    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        stall     = '0;
        flush     = 1'b0;
        mdu_busy  = 1'b0;
        mdu_done  = 1'b0;

        if (rst) begin
            state_d   = RUN;
            mdu_cnt_d = 6'd0;
        end else begin
            mdu_busy = start_ok || (state_q == MDU_WAIT);
            if (except_req) begin
                flush     = 1'b1;
                state_d   = RUN;
                mdu_cnt_d = 6'd0;
            end else begin
                if (stallreq_mem)      stall = STALL_MEM;
                else if (mdu_busy)     stall = STALL_EX;
                else if (stallreq_id)  stall = STALL_ID;

                // The MDU sequence advances even while MEM holds the pipe.
                case (state_q)
                    RUN: begin
                        if (mdu_start) begin
                            if (n_eff == 6'd1) begin
                                mdu_done = 1'b1;
                            end else begin
                                state_d   = MDU_WAIT;
                                mdu_cnt_d = n_eff - 6'd1;
                            end
                        end
                    end
                    MDU_WAIT: begin
                        mdu_cnt_d = mdu_cnt_q - 6'd1;
                        if (mdu_cnt_q == 6'd1) begin
                            mdu_done = 1'b1;
                            state_d  = RUN;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rst)
            stall_cnt_d = '0;
        else if ((stall != '0) && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values; the synchronous reset is folded into the _d logic.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        mdu_cnt_q   <= mdu_cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a sequence-level model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, stallreq_id, stallreq_mem, mdu_start, except_req;
    logic [5:0]  mdu_cycles;
    logic [5:0]  stall, stall4;
    logic        flush, mdu_busy, mdu_done;
    logic        flush4, busy4, done4;
    logic [31:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_ctrl u_dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .mdu_start(mdu_start), .mdu_cycles(mdu_cycles), .except_req(except_req),
        .stall(stall), .flush(flush), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.STALL_W(6), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .mdu_start(mdu_start), .mdu_cycles(mdu_cycles), .except_req(except_req),
        .stall(stall4), .flush(flush4), .mdu_busy(busy4), .mdu_done(done4),
        .stall_cnt(stall_cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Model: an MDU op of length n occupies cycles 1..n; seq_k is the index of
    // the current cycle inside the running op. cnt is the unbounded stall count.
    bit      model_valid = 0;
    bit      in_seq = 0;
    int      seq_n = 0, seq_k = 0;
    longint  cnt = 0;

    logic [5:0] last_stall;
    logic       last_flush, last_busy, last_done;

    task automatic step();
        logic [5:0] e_stall;
        logic       e_flush, e_busy, e_done;
        int         n;
        @(negedge clk);
        n       = (mdu_cycles == 0) ? 1 : int'(mdu_cycles);
        e_stall = 6'b0; e_flush = 0; e_busy = 0; e_done = 0;
        if (!rst) begin
            e_busy = in_seq || mdu_start;
            if (except_req) begin
                e_flush = 1;
            end else begin
                if (stallreq_mem)     e_stall = 6'b011111;
                else if (e_busy)      e_stall = 6'b001111;
                else if (stallreq_id) e_stall = 6'b000111;
                e_done = in_seq ? (seq_k == seq_n) : (mdu_start && n == 1);
            end
        end

        check("stall", stall, e_stall);
        check("flush", flush, e_flush);
        check("mdu_done", mdu_done, e_done);
        if (rst || !except_req) check("mdu_busy", mdu_busy, e_busy);
        check("stall4", stall4, e_stall);
        if (model_valid) begin
            check("stall_cnt", stall_cnt, (cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : cnt);
            check("stall_cnt4", stall_cnt4, (cnt > 15) ? 15 : cnt);
        end
        last_stall = stall; last_flush = flush; last_busy = mdu_busy; last_done = mdu_done;

        if (rst) begin
            in_seq = 0; cnt = 0; model_valid = 1;
        end else begin
            if (e_stall != 0) cnt++;
            if (except_req) begin
                in_seq = 0;
            end else if (in_seq) begin
                if (seq_k == seq_n) in_seq = 0;
                else seq_k++;
            end else if (mdu_start && n > 1) begin
                in_seq = 1; seq_n = n; seq_k = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stallreq_id = 0; stallreq_mem = 0; mdu_start = 0;
        mdu_cycles = 6'd0; except_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        check("rst_stall", last_stall, 6'b0);
        check("rst_flags", {last_flush, last_busy, last_done}, 3'b000);
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;

        // Single-cycle load-use stall.
        do_reset();
        check("cnt_after_reset", stall_cnt, 0);
        stallreq_id = 1; step();
        check("id_stall", last_stall, 6'b000111);
        stallreq_id = 0; step();
        check("id_released", last_stall, 6'b0);
        check("id_cnt", stall_cnt, 1);

        // N=4 MDU op.
        do_reset();
        mdu_start = 1; mdu_cycles = 6'd4;
        for (int i = 1; i <= 4; i++) begin
            step();
            mdu_start = 0;
            check("mdu4_stall", last_stall, 6'b001111);
            check("mdu4_busy", last_busy, 1'b1);
            check("mdu4_done", last_done, i == 4);
        end
        step();
        check("mdu4_after", {last_busy, last_stall}, 7'b0);
        check("mdu4_cnt", stall_cnt, 4);

        // N=0 and N=1 both take one cycle.
        for (int c = 0; c <= 1; c++) begin
            do_reset();
            mdu_start = 1; mdu_cycles = 6'(c); step();
            check("mdu1_stall", last_stall, 6'b001111);
            check("mdu1_done", last_done, 1'b1);
            mdu_start = 0; step();
            check("mdu1_run", {last_busy, last_stall}, 7'b0);
        end

        // N=6 with a MEM wait in cycles 2-3.
        do_reset();
        mdu_start = 1; mdu_cycles = 6'd6;
        for (int i = 1; i <= 6; i++) begin
            stallreq_mem = (i == 2 || i == 3);
            step();
            mdu_start = 0;
            check("mdu6_stall", last_stall, (i == 2 || i == 3) ? 6'b011111 : 6'b001111);
            check("mdu6_done", last_done, i == 6);
        end
        stallreq_mem = 0;

        // Exception in cycle 3 of N=8, then a new op is accepted.
        do_reset();
        mdu_start = 1; mdu_cycles = 6'd8;
        for (int i = 1; i <= 3; i++) begin
            except_req = (i == 3);
            step();
            mdu_start = 0;
        end
        check("exc_flush", last_flush, 1'b1);
        check("exc_stall", last_stall, 6'b0);
        check("exc_done", last_done, 1'b0);
        except_req = 0; mdu_start = 1; mdu_cycles = 6'd2; step();
        check("exc_restart", {last_busy, last_stall}, 7'b1001111);
        mdu_start = 0; step();
        check("exc_restart_done", last_done, 1'b1);

        // Reset mid-sequence produces no done pulse.
        do_reset();
        mdu_start = 1; mdu_cycles = 6'd5; step();
        mdu_start = 0; step();
        rst = 1; step();
        check("rst_mid_done", last_done, 1'b0);
        rst = 0; step();
        check("rst_mid_idle", {last_busy, last_stall}, 7'b0);

        // Counter saturation on the 4-bit build.
        do_reset();
        stallreq_mem = 1;
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt4", stall_cnt4, 4'hF);
        check("sat_cnt32", stall_cnt, 20);
        stallreq_mem = 0; rst = 1; step();
        rst = 0; step();
        check("sat_reset", stall_cnt4, 4'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            except_req   = ($urandom_range(0, 15) == 0);
            stallreq_mem = ($urandom_range(0, 4) == 0);
            stallreq_id  = ($urandom_range(0, 3) == 0);
            mdu_start    = ($urandom_range(0, 5) == 0);
            mdu_cycles   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                      : 6'($urandom_range(0, 9));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
